// File: rtl/simmem_pkg.sv
// Shared defaults and entry packing for the simulated-memory response path.
package simmem_pkg;

  localparam int unsigned DefaultDataWidth     = 32;
  localparam int unsigned DefaultIDWidth       = 4;
  localparam int unsigned DefaultTotalCapacity = 64;

  // Entry packing used on data_i/data_o: payload above, ID in the low bits.
  typedef struct packed {
    logic [DefaultDataWidth-1:0] payload;
    logic [DefaultIDWidth-1:0]   id;
  } entry_t;

endpackage

// File: rtl/simmem_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index and any-set flag.
module simmem_prio_enc #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    onehot_o = req_i & (~req_i + Width'(1));
    any_o    = |req_i;
    idx_o    = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = i[IdxW-1:0];
    end
  end

endmodule

// File: rtl/simmem_resp_bank.sv
// Response bank: per-ID FIFO linked lists over a shared slot pool, drained through
// one output register with fixed lowest-ID priority among released IDs.
module simmem_resp_bank
  import simmem_pkg::*;
#(
  parameter int unsigned DataWidth     = DefaultDataWidth,
  parameter int unsigned IDWidth       = DefaultIDWidth,
  parameter int unsigned TotalCapacity = DefaultTotalCapacity,
  localparam int unsigned NumIds       = 2 ** IDWidth,
  localparam int unsigned CntW         = $clog2(TotalCapacity + 1),
  localparam int unsigned EntryW       = IDWidth + DataWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [EntryW-1:0]      data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NumIds-1:0]      release_en_i,
  output logic [EntryW-1:0]      data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [CntW-1:0]        free_cnt_o,
  output logic [NumIds*CntW-1:0] id_cnt_o
);

  localparam int unsigned SlotW = $clog2(TotalCapacity);

  logic [TotalCapacity-1:0] valid_q, valid_d;
  logic [DataWidth-1:0]     payload_q [TotalCapacity];
  logic [SlotW-1:0]         next_q    [TotalCapacity];
  logic [SlotW-1:0]         head_q [NumIds], head_d [NumIds];
  logic [SlotW-1:0]         tail_q [NumIds], tail_d [NumIds];
  logic [CntW-1:0]          cnt_q  [NumIds], cnt_d  [NumIds];
  logic [CntW-1:0]          free_cnt_q, free_cnt_d;
  logic [EntryW-1:0]        out_q;
  logic                     out_valid_q;

  logic [TotalCapacity-1:0] free_oh, pop_slot_oh;
  logic [SlotW-1:0]         free_idx, pop_slot;
  logic                     free_any;
  logic [NumIds-1:0]        nonempty, id_oh, push_oh;
  logic [IDWidth-1:0]       id_sel, push_id;
  logic                     id_any;
  logic [DataWidth-1:0]     push_payload;
  logic                     push, pop, loadable;

  simmem_prio_enc #(
    .Width (TotalCapacity)
  ) u_free_enc (
    .req_i    (~valid_q),
    .onehot_o (free_oh),
    .idx_o    (free_idx),
    .any_o    (free_any)
  );

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      nonempty[i] = cnt_q[i] != '0;
    end
  end

  simmem_prio_enc #(
    .Width (NumIds)
  ) u_id_arb (
    .req_i    (release_en_i & nonempty),
    .onehot_o (id_oh),
    .idx_o    (id_sel),
    .any_o    (id_any)
  );

  assign push_id      = data_i[IDWidth-1:0];
  assign push_payload = data_i[EntryW-1:IDWidth];
  assign in_ready_o   = free_cnt_q != '0;
  assign loadable     = !out_valid_q || out_ready_i;
  assign push         = in_valid_i && in_ready_o && free_any;
  assign pop          = loadable && id_any;
  assign pop_slot     = head_q[id_sel];

  always_comb begin
    push_oh              = '0;
    push_oh[push_id]     = 1'b1;
    pop_slot_oh          = '0;
    pop_slot_oh[pop_slot] = 1'b1;

    valid_d = valid_q;
    if (push) valid_d = valid_d | free_oh;
    if (pop)  valid_d = valid_d & ~pop_slot_oh;
    free_cnt_d = free_cnt_q - CntW'(push) + CntW'(pop);

    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    for (int i = 0; i < NumIds; i++) begin
      if (pop && id_oh[i]) begin
        cnt_d[i]  = cnt_q[i] - CntW'(1);
        head_d[i] = next_q[head_q[i]];
      end
      if (push && push_oh[i]) begin
        cnt_d[i]  = cnt_d[i] + CntW'(1);
        tail_d[i] = free_idx;
        // A list that is empty after any same-cycle pop takes the new slot as head.
        if (cnt_d[i] == CntW'(1)) head_d[i] = free_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      free_cnt_q  <= CntW'(TotalCapacity);
      cnt_q       <= '{default: '0};
      head_q      <= '{default: '0};
      tail_q      <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      free_cnt_q <= free_cnt_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (pop) begin
        out_q       <= {payload_q[pop_slot], id_sel};
        out_valid_q <= 1'b1;
      end else if (loadable) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Storage arrays are qualified by the valid bitmap and counts, so they skip reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      payload_q[free_idx] <= push_payload;
      if (cnt_q[push_id] != '0) next_q[tail_q[push_id]] <= free_idx;
    end
  end

  assign data_o      = out_q;
  assign out_valid_o = out_valid_q;
  assign free_cnt_o  = free_cnt_q;

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      id_cnt_o[i*CntW +: CntW] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_simmem_resp_bank.sv
// Randomized and directed bench for simmem_resp_bank against a queue-based model.
module tb_simmem_resp_bank;

  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int CAP = 64;
  localparam int NID = 16;
  localparam int CW  = 7;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [IW+DW-1:0]  data_in, data_out;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [NID-1:0]    rel_en;
  logic [CW-1:0]     free_cnt;
  logic [NID*CW-1:0] id_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one queue per ID, an output slot and a free counter.
  logic [DW-1:0]    mq [NID][$];
  bit               m_ov = 1'b0;
  logic [IW+DW-1:0] m_data = '0;
  int               m_free = CAP;

  always #5 clk = ~clk;

  simmem_resp_bank u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_i       (data_in),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .release_en_i (rel_en),
    .data_o       (data_out),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .free_cnt_o   (free_cnt),
    .id_cnt_o     (id_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < NID; i++) mq[i].delete();
      m_ov   = 1'b0;
      m_data = '0;
      m_free = CAP;
    end else begin
      int sel;
      bit loadable;
      bit push_ok;
      loadable = !m_ov || out_ready;
      push_ok  = in_valid && (m_free > 0);
      sel = -1;
      if (loadable) begin
        for (int i = NID - 1; i >= 0; i--) begin
          if (rel_en[i] && mq[i].size() > 0) sel = i;
        end
      end
      if (sel >= 0) begin
        m_data = {mq[sel].pop_front(), 4'(sel)};
        m_ov   = 1'b1;
        m_free++;
      end else if (loadable) begin
        m_ov = 1'b0;
      end
      if (push_ok) begin
        mq[data_in[IW-1:0]].push_back(data_in[IW+DW-1:IW]);
        m_free--;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(m_free > 0));
    chk("free_cnt", 64'(free_cnt), 64'(m_free));
    for (int i = 0; i < NID; i++) begin
      chk($sformatf("id_cnt[%0d]", i), 64'(id_cnt[i*CW +: CW]), 64'(mq[i].size()));
    end
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov || !rst_n) chk("data_o", 64'(data_out), 64'(m_data));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [IW-1:0] id, input logic [DW-1:0] p);
    data_in  = {p, id};
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    rel_en    = '1;
    out_ready = 1'b1;
    k = 0;
    while (k < 200 && !(free_cnt == CW'(CAP) && !out_valid)) begin
      cyc(1);
      k++;
    end
    chk("drain_done", 64'(free_cnt == CW'(CAP) && !out_valid), 64'(1));
    rel_en    = '0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [IW+DW-1:0] held;
    in_valid  = 1'b0;
    data_in   = '0;
    rel_en    = '0;
    out_ready = 1'b0;
    cyc(3);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_free", 64'(free_cnt), 64'(64));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(data_out), 64'(0));
    chk("rst_id_cnt", 64'(id_cnt == '0), 64'(1));
    #2 rst_n = 1'b1;
    cyc(1);

    // Held entry, then release.
    push(4'd3, 32'hA5);
    cyc(2);
    chk("a5_cnt", 64'(id_cnt[3*CW +: CW]), 64'(1));
    chk("a5_model_cnt", 64'(mq[3].size()), 64'(1));
    chk("a5_held", 64'(out_valid), 64'(0));
    rel_en[3] = 1'b1;
    cyc(1);
    chk("a5_valid", 64'(out_valid), 64'(1));
    chk("a5_data", 64'(data_out), 64'({32'hA5, 4'd3}));
    drain();

    // Three back-to-back entries on one ID stream out on consecutive cycles.
    rel_en    = '1;
    out_ready = 1'b1;
    data_in   = {32'h1, 4'd2};
    in_valid  = 1'b1;
    cyc(1);
    data_in = {32'h2, 4'd2};
    cyc(1);
    chk("seq_1", 64'(data_out), 64'({32'h1, 4'd2}));
    data_in = {32'h3, 4'd2};
    cyc(1);
    chk("seq_2", 64'(data_out), 64'({32'h2, 4'd2}));
    in_valid = 1'b0;
    cyc(1);
    chk("seq_3", 64'(data_out), 64'({32'h3, 4'd2}));
    chk("seq_3_valid", 64'(out_valid), 64'(1));
    cyc(1);
    chk("seq_free", 64'(free_cnt), 64'(64));
    rel_en    = '0;
    out_ready = 1'b0;

    // Fill the pool, try one more, then release one entry.
    in_valid = 1'b1;
    for (int k = 0; k < CAP; k++) begin
      data_in = {32'(k + 16'h100), 4'd0};
      cyc(1);
    end
    chk("full_ready", 64'(in_ready), 64'(0));
    chk("full_free", 64'(free_cnt), 64'(0));
    data_in = {32'hDEAD, 4'd0};
    cyc(1);
    in_valid = 1'b0;
    chk("full_ignored", 64'(id_cnt[0 +: CW]), 64'(64));
    rel_en[0] = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    rel_en = '0;
    chk("full_reopen", 64'(in_ready), 64'(1));
    chk("full_first", 64'(data_out), 64'({32'h100, 4'd0}));
    drain();

    // Lowest released ID wins.
    push(4'd5, 32'h55);
    push(4'd1, 32'h11);
    rel_en    = '1;
    out_ready = 1'b1;
    cyc(1);
    chk("prio_first", 64'(data_out), 64'({32'h11, 4'd1}));
    cyc(1);
    chk("prio_second", 64'(data_out), 64'({32'h55, 4'd5}));
    drain();

    // Stall with release toggling.
    push(4'd4, 32'h44);
    push(4'd6, 32'h66);
    rel_en    = 16'h0010;
    out_ready = 1'b0;
    cyc(1);
    held = data_out;
    chk("stall_load", 64'(data_out), 64'({32'h44, 4'd4}));
    for (int k = 0; k < 10; k++) begin
      rel_en = 16'($urandom);
      cyc(1);
      chk("stall_data", 64'(data_out), 64'(held));
      chk("stall_cnt6", 64'(id_cnt[6*CW +: CW]), 64'(1));
    end
    drain();

    // Simultaneous push and pop on a single-entry ID.
    push(4'd7, 32'h11);
    rel_en    = 16'h0080;
    out_ready = 1'b1;
    data_in   = {32'hBB, 4'd7};
    in_valid  = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    chk("pp_cnt7", 64'(id_cnt[7*CW +: CW]), 64'(1));
    chk("pp_out", 64'(data_out), 64'({32'h11, 4'd7}));
    cyc(1);
    chk("pp_next", 64'(data_out), 64'({32'hBB, 4'd7}));
    chk("pp_valid", 64'(out_valid), 64'(1));
    drain();

    // Random traffic with alternating fill/drain phases and a mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      int phase;
      phase    = c / 500;
      in_valid = $urandom_range(0, 99) < ((phase % 2) ? 90 : 50);
      data_in  = {32'($urandom), 4'($urandom_range(0, (phase % 3 == 0) ? 3 : 15))};
      rel_en   = (phase % 2) ? 16'($urandom & $urandom) : 16'($urandom);
      out_ready = $urandom_range(0, 99) < ((phase % 2) ? 20 : 70);
      if (c == 2222) #2 rst_n = 1'b0;
      if (c == 2224) #2 rst_n = 1'b1;
      cyc(1);
    end
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/simmem_resp_bank.md
SIMMEM_RESP_BANK -- requirements
Module: simmem_resp_bank

Interface
REQ-001 SHALL have parameter DataWidth, default 32: payload bits per entry, ID excluded.
REQ-002 SHALL have parameter IDWidth, default 4: ID field width; NumIds = 2**IDWidth.
REQ-003 SHALL have parameter TotalCapacity, default 64: total entries shared by all IDs; must be ≥2.
REQ-004 SHALL have port clk_i  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_i  input  IDWidth+DataWidth  {payload, id}; id in bits [IDWidth-1:0].
REQ-007 SHALL have port in_valid_i  input  1  input entry valid.
REQ-008 SHALL have port in_ready_o  output  1  bank can accept an entry.
REQ-009 SHALL have port release_en_i  input  NumIds  per-ID permission to release.
REQ-010 SHALL have port data_o  output  IDWidth+DataWidth  released entry, same packing as data_i.
REQ-011 SHALL have port out_valid_o  output  1  data_o valid.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts data_o.
REQ-013 SHALL have port free_cnt_o  output  CntW  number of free entries; CntW = $clog2(TotalCapacity+1).
REQ-014 SHALL have port id_cnt_o  output  NumIds*CntW  stored entries per ID, ID0 in LSBs; excludes the output register.

Function
REQ-015 SHALL keep one FIFO-ordered linked list per ID over a shared pool: payload array, next-pointer array, per-ID head/tail/count, valid bitmap.
REQ-016 SHALL assert in_ready_o iff free_cnt_o > 0; in_ready_o SHALL NOT depend on in_valid_i or out_ready_i.
REQ-017 On push (in_valid_i & in_ready_o), SHALL write to the lowest-index free slot, link it after the ID's tail (or make it head and tail if count is 0), and increment that ID's count.
REQ-018 SHALL hold a single output register; the register is "loadable" when out_valid_o is 0 or out_ready_i is 1.
REQ-019 When the register is loadable, SHALL pop the head of the lowest-index ID with release_en_i set and count > 0 into the register; otherwise out_valid_o SHALL clear after a handshake.
REQ-020 A pop SHALL free the head slot, advance head to next, and decrement the count.
REQ-021 Latency: an entry pushed in cycle N, with its ID enabled and empty, SHALL appear on out_valid_o no earlier and no later than cycle N+2; no same-cycle bypass.
REQ-022 data_o/out_valid_o SHALL remain stable while out_valid_o=1 and out_ready_i=0, regardless of release_en_i changes.
REQ-023 Push and pop in the same cycle SHALL both complete, including same ID; same ID with count 1 SHALL leave the new entry as sole head/tail.
REQ-024 Freed slot in cycle N SHALL NOT be reused before cycle N+1; free_cnt_o SHALL be net-updated (+pop −push).
REQ-025 When full, in_ready_o=0 and in_valid_i SHALL be ignored with no state change; the input side SHALL NOT overflow.
REQ-026 Per-ID order SHALL be strict FIFO; inter-ID order SHALL follow fixed lowest-ID priority.

Reset
REQ-027 During reset: out_valid_o=0, data_o=0, in_ready_o=1, free_cnt_o=TotalCapacity, all id_cnt_o fields 0, valid bitmap cleared.
REQ-028 Reset mid-operation SHALL discard all stored entries and the output register contents; payload/next arrays need no reset.

Structure
REQ-029 SHALL place IDWidth/DataWidth defaults and packed entry typedef in shared package simmem_pkg.
REQ-030 SHALL use one sub-module simmem_prio_enc (lowest-set-bit onehot plus binary index plus any-valid), instantiated for free-slot search and ID arbitration.

Verification
REQ-031 Reset, push ID3 payload 0xA5 with release_en=0 -> id_cnt[3]=1, out_valid_o stays 0; set release_en[3] -> out_valid_o=1 next cycle with data_o={0xA5,3}.
REQ-032 Push ID2 entries 0x1,0x2,0x3, all enabled, out_ready_i=1 -> outputs 0x1,0x2,0x3 on consecutive cycles; free_cnt_o returns to 64.
REQ-033 Fill 64 entries to ID0 with release disabled -> in_ready_o=0, free_cnt_o=0; 65th push ignored; enable one pop -> in_ready_o=1 one cycle later.
REQ-034 IDs 1 and 5 each hold one entry, both enabled -> ID1 entry output first, then ID5.
REQ-035 out_ready_i=0 for 10 cycles with out_valid_o=1, toggle release_en_i -> data_o unchanged, counts unchanged.
REQ-036 ID7 count=1, simultaneous push ID7 0xBB and pop -> id_cnt[7] stays 1; next output is 0xBB.
